load_ext_stage: RTL and testbench
=================================

// Module: load_ext_stage
// PURPOSE
//   Registered load-data extender for the MEM->WB boundary. Extracts a byte, halfword or word lane
//   from the aligned memory word by byte offset, then sign- or zero-extends it to DATA_WIDTH.
//   Valid/ready handshake on both sides with a 2-entry skid buffer, so a WB stall never drops data.
//   Synchronous flush for pipeline squash. Generalises the plain sign extender: width, mode, buffering.
// PARAMETERS
//   DATA_WIDTH  32  word width in bits; multiple of 16, >= 32
//   OFF_BITS    2   byte-offset width; must equal log2(DATA_WIDTH/8)
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous, active-high reset
//   flush      in   1           sync squash of all buffered entries
//   in_valid   in   1           upstream entry valid
//   in_ready   out  1           stage can accept (registered)
//   in_data    in   DATA_WIDTH  raw aligned memory word
//   in_off     in   OFF_BITS    byte offset of access within word
//   in_size    in   2           0=byte 1=half 2=word 3=reserved
//   in_signed  in   1           1=sign-extend, 0=zero-extend
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream accepts
//   out_data   out  DATA_WIDTH  extended result
//   out_err    out  1           misaligned/reserved access flag for this result
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_err=0, in_ready=1, buffer EMPTY.
//   Lanes: byte = in_data[8*off +: 8]; half = in_data[8*off +: 16]; word = full in_data.
//   Extension: fill bits above lane = lane MSB if in_signed else 0; word ignores in_signed.
//   Error: half with off[0]=1, word with off!=0, or size=3 -> out_err=1, out_data=0.
//   Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
//   Latency: 1 cycle from input fire to out_valid with empty buffer; throughput 1/cycle.
//   States (main reg M, skid reg S):
//     EMPTY: in fire -> ONE (result into M).
//     ONE:   in fire & out fire -> ONE (M replaced); in fire only -> TWO (result into S);
//            out fire only -> EMPTY.
//     TWO:   in_ready=0; out fire -> ONE (S moves to M); else hold.
//   in_ready = (state != TWO), registered; may deassert the cycle after an unaccepted output.
//   out_data/out_err held stable while out_valid & !out_ready; no change until fire.
//   flush: next state EMPTY, out_valid=0, in_ready=1; overrides same-cycle in fire (input dropped).
//   out_data/out_err keep last value after flush or drain; only out_valid is meaningful.
//   rst mid-transfer: immediate EMPTY regardless of clk; buffered entries discarded.
//   Computation is done on input side; M and S hold already-extended results.
// TESTING
//   Byte signed: data=0x12_80_34_56, off=2, size=0, signed=1 -> out_data=0xFFFFFF80, err=0, 1 cycle.
//   Byte unsigned same word, off=2 -> 0x00000080; half off=2 signed, data=0x8001_0000 -> 0xFFFF8001.
//   Misaligned: size=1 off=1 -> out_err=1, out_data=0; size=3 any off -> out_err=1.
//   Backpressure: out_ready=0, push 3 back-to-back -> 2 held, in_ready=0 on 3rd; release -> order kept.
//   Flush with TWO state and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, nothing lost later.
//   Async rst asserted mid-clock with out_valid=1 -> out_valid=0 before next edge; stream resumes.

Source files
------------

// File: rtl/load_ext_stage.sv
// Registered load-data extender for the MEM->WB boundary: picks the byte/half/word lane,
// sign- or zero-extends it, and buffers up to two results behind a valid/ready handshake.
module load_ext_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFF_BITS-1:0]   in_off,
  input  logic [1:0]            in_size,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  // Returns {err, extended value}; errored accesses yield a zero value.
  function automatic logic [DATA_WIDTH:0] extend_lane(
    input logic [DATA_WIDTH-1:0] data,
    input logic [OFF_BITS-1:0]   off,
    input logic [1:0]            size,
    input logic                  sgn
  );
    logic [7:0]            lane8;
    logic [15:0]           lane16;
    logic [DATA_WIDTH-1:0] res;
    logic                  err;
    lane8  = data[{off, 3'b000} +: 8];
    lane16 = data[{off, 3'b000} +: 16];
    res    = '0;
    err    = 1'b0;
    case (size)
      2'd0: res = {{(DATA_WIDTH-8){sgn & lane8[7]}}, lane8};
      2'd1: begin
        if (off[0]) err = 1'b1;
        else        res = {{(DATA_WIDTH-16){sgn & lane16[15]}}, lane16};
      end
      2'd2: begin
        if (off != '0) err = 1'b1;
        else           res = data;
      end
      default: err = 1'b1;
    endcase
    return {err, res};
  endfunction

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic                  m_err_q, m_err_d, s_err_q, s_err_d;
  logic [DATA_WIDTH:0]   res;
  logic                  in_take, out_take;

  assign res      = extend_lane(in_data, in_off, in_size, in_signed);
  // A flush squashes both handshakes so the held result registers stay untouched.
  assign in_take  = in_valid & in_ready_q & ~flush;
  assign out_take = out_valid & out_ready & ~flush;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_err_d  = m_err_q;
    s_data_d = s_data_q;
    s_err_d  = s_err_q;
    case (state_q)
      EMPTY: begin
        if (in_take) begin
          {m_err_d, m_data_d} = res;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_take && out_take) begin
          {m_err_d, m_data_d} = res;
        end else if (in_take) begin
          {s_err_d, s_data_d} = res;
          state_d = TWO;
        end else if (out_take) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_take) begin
          m_data_d = s_data_q;
          m_err_d  = s_err_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      m_err_q    <= m_err_d;
    end
  end

  // Skid register only carries data that is qualified by the state, so it needs no reset.
  always_ff @(posedge clk) begin
    s_data_q <= s_data_d;
    s_err_q  <= s_err_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_data_q;
  assign out_err   = m_err_q;

endmodule

// File: tb/tb_load_ext_stage.sv
// Scoreboard bench for load_ext_stage: expected results are queued on input fire
// and compared on output fire, with scenario tasks adding direct timing checks.
module tb_load_ext_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_off = '0;
  logic [1:0]    in_size = '0;
  logic          in_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_err;

  int errors = 0;
  int checks = 0;
  int popped = 0;
  logic rand_rdy = 1'b0;
  logic [DW:0] sb[$];

  load_ext_stage #(.DATA_WIDTH(DW), .OFF_BITS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_off(in_off), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW:0] model(input logic [DW-1:0] d, input logic [1:0] off,
                                        input logic [1:0] size, input logic sgn);
    logic [DW-1:0] v;
    v = d >> (8 * off);
    case (size)
      2'd0: return (sgn && v[7]) ? {1'b0, 32'hFFFFFF00 | (v & 32'hFF)} : {1'b0, v & 32'hFF};
      2'd1: begin
        if (off[0]) return {1'b1, 32'h0};
        return (sgn && v[15]) ? {1'b0, 32'hFFFF0000 | (v & 32'hFFFF)} : {1'b0, v & 32'hFFFF};
      end
      2'd2: return (off != 2'd0) ? {1'b1, 32'h0} : {1'b0, d};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Scoreboard: pop on output fire, push on input fire, both sampled mid-cycle.
  always @(negedge clk) begin
    logic [DW:0] exp;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=%h/%0b required=nothing pending", out_data, out_err);
        end else begin
          exp = sb.pop_front();
          popped++;
          if ({out_err, out_data} !== exp) begin
            errors++;
            $display("FAIL sb_data got err=%0b data=%h required err=%0b data=%h",
                     out_err, out_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(in_data, in_off, in_size, in_signed));
    end
  end

  task automatic set_in(input logic [DW-1:0] d, input logic [1:0] off,
                        input logic [1:0] size, input logic sgn);
    in_valid = 1'b1; in_data = d; in_off = off; in_size = size; in_signed = sgn;
  endtask

  // Hold the current input until accepted; leaves in_valid high for the caller.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] off,
                      input logic [1:0] size, input logic sgn);
    logic acc;
    set_in(d, off, size, sgn);
    for (int i = 0; i < 50; i++) begin
      if (rand_rdy) out_ready = $urandom_range(0, 1) == 1;
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    checks++; errors++;
    $display("FAIL send_timeout got=no accept required=accept within 50 cycles");
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; rand_rdy = 1'b0;
    for (int i = 0; i < 50 && (out_valid || sb.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid || sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=valid %0b pending %0d required=idle", out_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_err, out_data, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset got v=%0b e=%0b d=%h r=%0b required v=0 e=0 d=0 r=1",
               out_valid, out_err, out_data, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_extend();
    logic [DW-1:0] vec_d[3]   = '{32'h12803456, 32'h12803456, 32'h80010000};
    logic [1:0]    vec_sz[3]  = '{2'd0, 2'd0, 2'd1};
    logic          vec_sg[3]  = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] vec_exp[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(vec_d[i], 2'd2, vec_sz[i], vec_sg[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== vec_exp[i]) begin
        errors++;
        $display("FAIL extend_%0d got v=%0b e=%0b d=%h required v=1 e=0 d=%h",
                 i, out_valid, out_err, out_data, vec_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_misaligned();
    logic [1:0] vec_off[4] = '{2'd1, 2'd0, 2'd3, 2'd2};
    logic [1:0] vec_sz[4]  = '{2'd1, 2'd3, 2'd3, 2'd2};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(32'hDEADBEEF, vec_off[i], vec_sz[i], 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 32'h0) begin
        errors++;
        $display("FAIL misaligned_%0d got v=%0b e=%0b d=%h required v=1 e=1 d=0",
                 i, out_valid, out_err, out_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    popped = 0;
    send(32'h000000A1, 2'd0, 2'd0, 1'b0);
    send(32'h0000B200, 2'd1, 2'd0, 1'b0);
    set_in(32'hC3000000, 2'd3, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA1) begin
      errors++;
      $display("FAIL backpressure_hold got r=%0b v=%0b d=%h required r=0 v=1 d=000000a1",
               in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    send(32'hC3000000, 2'd3, 2'd0, 1'b0);
    drain();
    checks++;
    if (popped != 3) begin
      errors++;
      $display("FAIL backpressure_count got=%0d required=3", popped);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h11111111, 2'd0, 2'd2, 1'b0);
    send(32'h22222222, 2'd0, 2'd2, 1'b0);
    set_in(32'h33333333, 2'd0, 2'd2, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    send(32'h44444444, 2'd0, 2'd2, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h44444444) begin
      errors++;
      $display("FAIL flush_resume got v=%0b d=%h required v=1 d=44444444", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h55555555, 2'd0, 2'd2, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%0b r=%0b d=%h required v=0 r=1 d=0",
               out_valid, in_ready, out_data);
    end
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0000807F, 2'd0, 2'd1, 1'b1);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF807F) begin
      errors++;
      $display("FAIL async_resume got v=%0b d=%h required v=1 d=ffff807f", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++)
      send($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    drain();
  endtask

  initial begin
    test_reset();
    test_extend();
    test_misaligned();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
